// File: rtl/sorting_hardware.sv
// sorting_hardware: Avalon-MM in-place bubble sort of 32-bit unsigned words in SDRAM.
// Define SORT_DESCENDING_EN to sort in descending order instead of ascending.
module sorting_hardware #(
    parameter int DEFAULT_LEN = 8,
    parameter int ADDR_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    output logic        master_write,
    output logic [31:0] master_writedata,
    output logic [9:1]  LEDR
);
    typedef enum logic [2:0] {INIT, LOAD1, LOAD2, CMP, SWITCH, SWITCH2, DONE} state_t;
    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_t      state_q, state_d;
    logic [31:0] base_q, len_q, cnt_q, cnt_d, i_q, i_d, data1_q, data1_d, data2_q, data2_d;
    logic        swapped_q, swapped_d;
    logic        busy, done, start, swap, last;
    logic        rd_d, wr_d;
    logic [31:0] addr_d, wdata_d;
    logic        unused;

    assign unused = ^{slave_read, slave_address[31:2]};
    assign busy   = state_q != INIT && state_q != DONE;
    assign done   = state_q == DONE;
    assign start  = slave_write && slave_address[1:0] == 2'd0;
    assign last   = (i_q + 32'd1) >= (len_q - 32'd1);
`ifdef SORT_DESCENDING_EN
    assign swap = data1_q < master_readdata;
`else
    assign swap = data1_q > master_readdata;
`endif

    assign slave_waitrequest = busy;
    assign LEDR = {done, busy, state_q, cnt_q[3:0]};
    assign slave_readdata = slave_address[1:0] == 2'd0 ? {31'b0, done} :
                            slave_address[1:0] == 2'd1 ? base_q :
                            slave_address[1:0] == 2'd2 ? len_q : cnt_q;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        swapped_d = swapped_q;
        cnt_d     = cnt_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        case (state_q)
            INIT, DONE: if (start) begin
                state_d   = len_q < 32'd2 ? DONE : LOAD1;
                i_d       = '0;
                swapped_d = 1'b0;
            end
            LOAD1: state_d = LOAD2;
            LOAD2: begin
                data1_d = master_readdata;
                state_d = CMP;
            end
            SWITCH: begin
                swapped_d = 1'b1;
                cnt_d     = cnt_q + 32'd1;
                state_d   = SWITCH2;
            end
            default: begin
                if (state_q == CMP) data2_d = master_readdata;
                if (state_q == CMP && swap) state_d = SWITCH;
                else if (!last) begin
                    i_d     = i_q + 32'd1;
                    state_d = LOAD1;
                end else if (swapped_q) begin
                    i_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = LOAD1;
                end else state_d = DONE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_comb begin
        rd_d    = state_d == LOAD1 || state_d == LOAD2;
        wr_d    = state_d == SWITCH || state_d == SWITCH2;
        addr_d  = (state_d == LOAD2 || state_d == SWITCH2) ? base_q + (i_d + 32'd1) * STEP :
                  (rd_d || wr_d) ? base_q + i_d * STEP : '0;
        wdata_d = state_d == SWITCH ? data2_d : state_d == SWITCH2 ? data1_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= INIT;
            i_q              <= '0;
            swapped_q        <= 1'b0;
            cnt_q            <= '0;
            data1_q          <= '0;
            data2_q          <= '0;
            base_q           <= '0;
            len_q            <= 32'(DEFAULT_LEN);
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
        end else begin
            state_q          <= state_d;
            i_q              <= i_d;
            swapped_q        <= swapped_d;
            cnt_q            <= cnt_d;
            data1_q          <= data1_d;
            data2_q          <= data2_d;
            master_read      <= rd_d;
            master_write     <= wr_d;
            master_address   <= addr_d;
            master_writedata <= wdata_d;
            if (slave_write && !busy && slave_address[1:0] == 2'd1) base_q <= slave_writedata;
            if (slave_write && !busy && slave_address[1:0] == 2'd2) len_q <= slave_writedata;
        end
    end
endmodule

// File: tb/tb_sorting_hardware.sv
// tb_sorting_hardware: directed and randomized checks of sorting_hardware against an SDRAM model and a sorting reference.
module tb_sorting_hardware;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [31:0] slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [9:1]  LEDR;

    int tests = 0;
    int fails = 0;
    int acc = 0;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    sorting_hardware dut (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
        .slave_read(slave_read), .slave_readdata(slave_readdata),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .master_address(master_address), .master_read(master_read),
        .master_readdata(master_readdata), .master_write(master_write),
        .master_writedata(master_writedata), .LEDR(LEDR)
    );

    // SDRAM model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (master_write) mem[master_address[7:2]] = master_writedata;
        if (master_read) master_readdata <= mem[master_address[7:2]];
        if (master_read || master_write) acc = acc + 1;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        slave_write = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        slave_address = {30'b0, a};
        slave_writedata = d;
        slave_write = 1'b1;
        tick;
        slave_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        slave_address = {30'b0, a};
        slave_read = 1'b1;
        #1 d = slave_readdata;
        slave_read = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (LEDR[9] !== 1'b1 && n < budget) begin
            tick;
            n++;
        end
        chk("done_within_budget", {31'b0, LEDR[9]}, 32'd1);
    endtask

    function automatic bit out_of_order(input logic [31:0] a, input logic [31:0] b);
`ifdef SORT_DESCENDING_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    // Reference: final memory is the sorted array; swap count equals the number of out-of-order pairs.
    task automatic run_sort(input string tag, input int bw, input logic [31:0] arr[$]);
        logic [31:0] expq[$];
        logic [31:0] d;
        int inv = 0;
        int n = arr.size();
        do_reset;
        foreach (arr[k]) mem[bw + k] = arr[k];
        mem[bw + n] = 32'hA5A5_0000 + 32'(n);
        wr(2'd1, 32'(bw * 4));
        wr(2'd2, 32'(n));
        wr(2'd0, 32'd0);
        expq = arr;
`ifdef SORT_DESCENDING_EN
        expq.rsort();
`else
        expq.sort();
`endif
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (out_of_order(arr[a], arr[b])) inv++;
        wait_done(6000);
        for (int k = 0; k < n; k++) chk({tag, "_mem"}, mem[bw + k], expq[k]);
        chk({tag, "_guard"}, mem[bw + n], 32'hA5A5_0000 + 32'(n));
        rd(2'd3, d);
        chk({tag, "_swaps"}, d, 32'(inv));
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] q[$];
        int a0, n, bw;
        for (int k = 0; k < 64; k++) mem[k] = 32'(k);
        @(negedge clk);
        do_reset;
        chk("rst_wait", {31'b0, slave_waitrequest}, 32'd0);
        chk("rst_mrd", {31'b0, master_read}, 32'd0);
        chk("rst_mwr", {31'b0, master_write}, 32'd0);
        chk("rst_addr", master_address, 32'd0);
        chk("rst_led", {23'b0, LEDR}, 32'd0);
        rd(2'd2, d);
        chk("rst_len", d, 32'd8);
        rd(2'd1, d);
        chk("rst_base", d, 32'd0);

        // First compare/swap of a default-length sort
        mem[0] = 32'd1;
        mem[1] = 32'd0;
        wr(2'd0, 32'd0);
        chk("start_state", {29'b0, LEDR[7:5]}, 32'd1);
        chk("start_mrd", {31'b0, master_read}, 32'd1);
        chk("start_addr", master_address, 32'd0);
        chk("start_wait", {31'b0, slave_waitrequest}, 32'd1);
        tick;
        chk("load2_addr", master_address, 32'd4);
        chk("load2_data", master_readdata, 32'd1);
        tick;
        chk("cmp_data", master_readdata, 32'd0);
        tick;
        chk("sw_state", {29'b0, LEDR[7:5]}, 32'd4);
        chk("sw_mwr", {31'b0, master_write}, 32'd1);
        chk("sw_mrd", {31'b0, master_read}, 32'd0);
        chk("sw_addr", master_address, 32'd0);
        chk("sw_data", master_writedata, 32'd0);
        tick;
        chk("sw2_addr", master_address, 32'd4);
        chk("sw2_data", master_writedata, 32'd1);
        tick;
        chk("next_mrd", {31'b0, master_read}, 32'd1);
        chk("next_addr", master_address, 32'd4);
        wait_done(3000);
        for (int k = 0; k < 8; k++) chk("first_mem", mem[k], 32'(k));
        rd(2'd3, d);
        chk("first_swaps", d, 32'd1);

        // Already sorted: one pass, no swaps
        do_reset;
        for (int k = 0; k < 4; k++) mem[16 + k] = 32'(k + 1);
        wr(2'd1, 32'h40);
        wr(2'd2, 32'd4);
        wr(2'd0, 32'd0);
        wait_done(200);
        rd(2'd0, d);
        chk("sorted_done_reg", d, 32'd1);
        chk("sorted_led9", {31'b0, LEDR[9]}, 32'd1);
        chk("sorted_wait", {31'b0, slave_waitrequest}, 32'd0);
        rd(2'd3, d);
        chk("sorted_swaps", d, 32'd0);
        for (int k = 0; k < 4; k++) chk("sorted_mem", mem[16 + k], 32'(k + 1));

        // Reverse order, with a length write attempted while busy
        do_reset;
        for (int k = 0; k < 4; k++) mem[k] = 32'(4 - k);
        wr(2'd2, 32'd4);
        wr(2'd0, 32'd0);
        wr(2'd2, 32'd99);
        wait_done(500);
        for (int k = 0; k < 4; k++) chk("rev_mem", mem[k], 32'(k + 1));
        rd(2'd3, d);
        chk("rev_swaps", d, 32'd6);
        chk("rev_led_cnt", {28'b0, LEDR[4:1]}, 32'd6);
        rd(2'd2, d);
        chk("rev_len_locked", d, 32'd4);

        // N=1: straight to DONE with no bus traffic
        do_reset;
        wr(2'd2, 32'd1);
        a0 = acc;
        wr(2'd0, 32'd0);
        chk("n1_state", {29'b0, LEDR[7:5]}, 32'd6);
        chk("n1_wait", {31'b0, slave_waitrequest}, 32'd0);
        tick;
        tick;
        chk("n1_no_access", 32'(acc - a0), 32'd0);
        rd(2'd0, d);
        chk("n1_done", d, 32'd1);

        q = '{32'd5, 32'd2};
        run_sort("n2", 0, q);

        // Reset while in SWITCH
        do_reset;
        mem[0] = 32'd1;
        mem[1] = 32'd0;
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd0);
        for (int k = 0; k < 10 && LEDR[7:5] != 3'd4; k++) tick;
        chk("reach_switch", {29'b0, LEDR[7:5]}, 32'd4);
        rst_n = 1'b0;
        tick;
        chk("midrst_state", {29'b0, LEDR[7:5]}, 32'd0);
        chk("midrst_mwr", {31'b0, master_write}, 32'd0);
        chk("midrst_wait", {31'b0, slave_waitrequest}, 32'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(2, 12);
            bw = $urandom_range(0, 40);
            q = {};
            for (int k = 0; k < n; k++) q.push_back(t[0] ? 32'($urandom_range(0, 3)) : 32'($urandom));
            run_sort("rand", bw, q);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
